cipher_pipe: RTL and testbench
==============================

CIPHER_PIPE -- requirements
Module: cipher_pipe

Interface
REQ-001 Parameter N, default 8, data/key width in bits; legal range N >= 2.
REQ-002 Parameter ROT, default 3, rotate amount in bits; legal range 1..N-1.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input beat offered.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_mode  input  1  per-beat mode: 0 = ENC, 1 = DEC.
REQ-008 in_key  input  N  per-beat key.
REQ-009 in_data  input  N  per-beat plaintext (ENC) or ciphertext (DEC).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts the result beat.
REQ-012 out_mode  output  1  mode of the result beat.
REQ-013 out_data  output  N  result beat.
REQ-014 busy  output  1  high while any pipeline stage holds a valid beat.

Function
REQ-015 A beat transfers on input when in_valid and in_ready are both high at a rising edge; it transfers on output when out_valid and out_ready are both high.
REQ-016 The datapath is a 5-stage registered pipeline; each stage carries its valid bit, its mode bit, its key and its N-bit word.
REQ-017 ENC stage operations, in order: S1 = data XOR key; S2 = rotate-left by ROT; S3 = bitwise NOT; S4 = bit reverse (bit i goes to bit N-1-i); S5 = rotate-right by ROT.
REQ-018 DEC stage operations, in order: S1 = rotate-left by ROT; S2 = bit reverse; S3 = bitwise NOT; S4 = rotate-right by ROT; S5 = XOR with the beat's key.
REQ-019 For all N, ROT, key and data, DEC(ENC(d, k), k) SHALL equal d.
REQ-020 Latency SHALL be exactly 5 cycles from input transfer to out_valid, with no backpressure applied.
REQ-021 Each stage SHALL load when it is empty or when its contents move downstream in the same cycle.
REQ-022 in_ready SHALL equal (S1 empty) OR (S1 advancing), where S1 advancing means S2 empty or S2 advancing, recursively down to out_ready; in_ready SHALL NOT depend on in_valid.
REQ-023 Sustained throughput SHALL be one beat per cycle while out_ready is held high.
REQ-024 While out_ready is low with out_valid high, out_data and out_mode SHALL hold stable; no beat is lost or duplicated; the pipeline fills to 5 beats and in_ready then drops.
REQ-025 ENC and DEC beats may be interleaved on consecutive cycles; each beat is processed in its own mode, and output order equals input order.
REQ-026 A beat offered while in_ready is low SHALL NOT be captured.
REQ-027 out_data, out_mode and out_valid SHALL be driven directly from S5 registers, with no combinational path from in_* to out_*.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear all stage valid bits, so that out_valid = 0 and busy = 0.
REQ-029 Asserting reset_n low SHALL immediately set out_data = 0 and out_mode = 0.
REQ-030 During reset, in_ready SHALL be 0; it rises on the first rising edge after reset_n deasserts.
REQ-031 Reset mid-stream SHALL discard all in-flight beats; none appear after release.

Structure
REQ-032 Shared package cipher_pkg SHALL hold the mode enum (ENC = 0, DEC = 1) and the default constants N_DEF = 8 and ROT_DEF = 3.
REQ-033 The per-stage record (valid, mode, key, word) SHALL be a packed struct local to cipher_pipe, sized by N.
REQ-034 A single sub-module, cipher_slice, SHALL implement one stage register with valid/ready hold logic; cipher_pipe instantiates it five times, and stage transforms stay in cipher_pipe.

Verification (N=8, ROT=3)
REQ-035 Reset check: ENC beat key=0x00, data=0x01 -> out_data=0xFD, out_mode=0, exactly 5 cycles after acceptance.
REQ-036 Round-trip check: DEC beat key=0x00, data=0xFD -> 0x01; ENC key=0x00, data=0x00 -> 0xFF; ENC key=0xA5, data=0x5A -> 0x00.
REQ-037 Streaming check: 256 back-to-back beats, ENC of data 0..255 with key 0x3C, with out_ready held 1 -> one result per cycle; each result decrypted back with DEC reproduces 0..255 in order.
REQ-038 Backpressure check: out_ready=0 for 10 cycles while streaming -> in_ready drops after 5 beats accepted, out_data stays stable, and all beats emerge in order once out_ready returns to 1.
REQ-039 Reset-abort check: reset_n pulsed low with 3 beats in flight -> out_valid=0 and busy=0 immediately, and no stale beat appears afterwards.
REQ-040 Random check: random in_valid and out_ready with mixed modes -> a scoreboard reference model matches every beat, and DEC(ENC(d, k), k) == d.

Source files
------------

// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared mode encoding and default widths for the cipher pipeline
package cipher_pkg;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  localparam int N_DEF   = 8;
  localparam int ROT_DEF = 3;

endpackage

// File: rtl/cipher_slice.sv
// rtl/cipher_slice.sv - one pipeline stage register with valid/ready hold logic
module cipher_slice #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_payload,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_payload,
  input  logic         out_ready
);

  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  // Load when empty or when the current beat leaves in this same cycle.
  always_comb begin
    in_ready  = !valid_q || out_ready;
    valid_d   = valid_q;
    payload_d = payload_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        payload_d = in_payload;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/cipher_pipe.sv
// rtl/cipher_pipe.sv - five-stage invertible bit-scrambling pipeline with per-beat ENC/DEC mode
module cipher_pipe
  import cipher_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int ROT = ROT_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_key,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int NS = 5;
  localparam int PW = 1 + 2 * N;

  typedef struct packed {
    logic         valid;
    mode_e        mode;
    logic [N-1:0] key;
    logic [N-1:0] word;
  } stage_t;

  function automatic logic [N-1:0] rol(input logic [N-1:0] x);
    return (x << ROT) | (x >> (N - ROT));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] x);
    return (x >> ROT) | (x << (N - ROT));
  endfunction

  function automatic logic [N-1:0] rev(input logic [N-1:0] x);
    logic [N-1:0] y;
    for (int b = 0; b < N; b++) begin
      y[N-1-b] = x[b];
    end
    return y;
  endfunction

  // DEC applies the inverse ENC operations in reverse order.
  function automatic logic [N-1:0] stage_op(input int idx, input mode_e m,
                                            input logic [N-1:0] w, input logic [N-1:0] k);
    logic [N-1:0] r;
    r = w;
    if (m == ENC) begin
      case (idx)
        0:       r = w ^ k;
        1:       r = rol(w);
        2:       r = ~w;
        3:       r = rev(w);
        default: r = ror(w);
      endcase
    end else begin
      case (idx)
        0:       r = rol(w);
        1:       r = rev(w);
        2:       r = ~w;
        3:       r = ror(w);
        default: r = w ^ k;
      endcase
    end
    return r;
  endfunction

  logic              accept_en_q, accept_en_d;
  stage_t            st_in [NS];
  stage_t            st_q  [NS];
  logic   [NS-1:0]   vld_q;
  logic   [PW-1:0]   pay_q [NS];
  logic   [NS-1:0]   rdy;
  logic   [NS-1:0]   dn_rdy;

  // Holds in_ready low until the first edge after reset release.
  always_comb begin
    accept_en_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      accept_en_q <= 1'b0;
    end else begin
      accept_en_q <= accept_en_d;
    end
  end

  always_comb begin
    st_in[0].valid = in_valid & accept_en_q;
    st_in[0].mode  = mode_e'(in_mode);
    st_in[0].key   = in_key;
    st_in[0].word  = stage_op(0, mode_e'(in_mode), in_data, in_key);
    for (int i = 1; i < NS; i++) begin
      st_in[i]      = st_q[i-1];
      st_in[i].word = stage_op(i, st_q[i-1].mode, st_q[i-1].word, st_q[i-1].key);
    end
  end

  assign dn_rdy = {out_ready, rdy[NS-1:1]};

  for (genvar g = 0; g < NS; g++) begin : g_stage
    cipher_slice #(
      .W(PW)
    ) u_slice (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (st_in[g].valid),
      .in_payload (st_in[g][PW-1:0]),
      .in_ready   (rdy[g]),
      .out_valid  (vld_q[g]),
      .out_payload(pay_q[g]),
      .out_ready  (dn_rdy[g])
    );
    assign st_q[g] = stage_t'({vld_q[g], pay_q[g]});
  end

  assign in_ready  = accept_en_q & rdy[0];
  assign out_valid = st_q[NS-1].valid;
  assign out_mode  = st_q[NS-1].mode;
  assign out_data  = st_q[NS-1].word;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_cipher_pipe.sv
// tb/tb_cipher_pipe.sv - scoreboard bench for cipher_pipe with a bit-level reference model
module tb_cipher_pipe;

  localparam int N   = 8;
  localparam int ROT = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic [7:0] in_key = 8'h00;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_mode;
  logic [7:0] out_data;
  logic       busy;

  cipher_pipe #(
    .N  (N),
    .ROT(ROT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_key   (in_key),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mode (out_mode),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic       mode;
    logic [7:0] key;
    logic [7:0] orig;
    logic [7:0] data;
    int         cyc;
    bit         lat;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      rt_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         collect = 0;
  int         or_mode = 1;
  int         out_seen = 0;
  bit         hold_pend = 0;
  logic [7:0] hold_data;
  logic       hold_mode;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
    logic [7:0] y;
    for (int i = 0; i < N; i++) y[(i + r) % N] = x[i];
    return y;
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] x, input int r);
    logic [7:0] y;
    for (int i = 0; i < N; i++) y[i] = x[(i + r) % N];
    return y;
  endfunction

  function automatic logic [7:0] bitrev(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < N; i++) y[N-1-i] = x[i];
    return y;
  endfunction

  function automatic logic [7:0] ref_enc(input logic [7:0] d, input logic [7:0] k);
    return rotr(bitrev(~rotl(d ^ k, ROT)), ROT);
  endfunction

  function automatic logic [7:0] ref_dec(input logic [7:0] c, input logic [7:0] k);
    return rotr(~bitrev(rotl(c, ROT)), ROT) ^ k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic m, input logic [7:0] k, input logic [7:0] d,
                          input logic [7:0] e, input bit lat);
    beat_t b;
    b.mode = m; b.key = k; b.orig = d; b.data = e; b.cyc = cyc; b.lat = lat;
    exp_q.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic m, input logic [7:0] k, input logic [7:0] d,
                      input logic [7:0] e, input bit lat);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_mode = m; in_key = k; in_data = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clock);
      if (in_ready) begin
        push_exp(m, k, d, e, lat);
        ok = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never high, expected acceptance within 100 cycles");
    end
  endtask

  task automatic drain();
    or_mode = 1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clock);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 9) < 6);
      endcase
    end
  end

  initial begin
    beat_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          if (!out_valid) chk("hold_valid", out_valid, 1);
          else begin
            chk("hold_data", out_data, hold_data);
            chk("hold_mode", out_mode, hold_mode);
          end
        end
        hold_pend = 0;
        if (out_valid) begin
          out_seen++;
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
            end else begin
              e = exp_q.pop_front();
              chk("out_data", out_data, e.data);
              chk("out_mode", out_mode, e.mode);
              if (e.lat) chk("latency", cyc - e.cyc, 5);
              if (collect && e.mode == 1'b0) begin
                e.data = out_data;
                rt_q.push_back(e);
              end
            end
          end else begin
            hold_pend = 1;
            hold_data = out_data;
            hold_mode = out_mode;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    beat_t rt_copy[$];
    int    acc;
    int    c0;
    logic  m;
    logic [7:0] k, d;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("in_ready_at_release", in_ready, 0);
    @(posedge clock);
    #1;
    chk("in_ready_after_edge", in_ready, 1);

    send(1'b0, 8'h00, 8'h01, 8'hFD, 1);
    drain();
    send(1'b1, 8'h00, 8'hFD, 8'h01, 1);
    send(1'b0, 8'h00, 8'h00, 8'hFF, 1);
    send(1'b0, 8'hA5, 8'h5A, 8'h00, 1);
    drain();
    chk("busy_idle", busy, 0);

    collect = 1;
    rt_q.delete();
    c0 = cyc;
    for (int i = 0; i < 256; i++) send(1'b0, 8'h3C, 8'(i), ref_enc(8'(i), 8'h3C), 1);
    chk("stream_cycles", cyc - c0, 256);
    drain();
    collect = 0;
    chk("stream_rt_count", rt_q.size(), 256);
    rt_copy = rt_q;
    foreach (rt_copy[i]) send(1'b1, rt_copy[i].key, rt_copy[i].data, 8'(i), 1);
    drain();

    or_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    acc = 0;
    for (int t = 0; t < 10; t++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_key = 8'h77; in_data = 8'(8'h10 + acc);
      @(negedge clock);
      if (in_ready) begin
        push_exp(1'b0, 8'h77, in_data, ref_enc(in_data, 8'h77), 0);
        acc++;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    or_mode = 1;
    for (int i = 0; i < 3; i++) send(1'b1, 8'h21, 8'(i * 37), ref_dec(8'(i * 37), 8'h21), 0);
    drain();

    for (int i = 0; i < 3; i++) send(1'b0, 8'h55, 8'(i + 1), ref_enc(8'(i + 1), 8'h55), 1);
    chk("busy_inflight", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_mode", out_mode, 0);
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    out_seen = 0;
    repeat (15) @(posedge clock);
    #1;
    chk("abort_no_stale", out_seen, 0);

    collect = 1;
    rt_q.delete();
    or_mode = 2;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) < 7) begin
        m = 1'($urandom_range(0, 1));
        k = 8'($urandom);
        d = 8'($urandom);
        send(m, k, d, m ? ref_dec(d, k) : ref_enc(d, k), 0);
      end else begin
        @(posedge clock);
        #1;
      end
    end
    drain();
    collect = 0;
    rt_copy = rt_q;
    or_mode = 2;
    foreach (rt_copy[i]) send(1'b1, rt_copy[i].key, rt_copy[i].data, rt_copy[i].orig, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
